// File: rtl/ifetch_seq.sv
// Instruction-fetch sequencer: reads four big-endian bytes from a byte-wide RAM,
// presents them as one 32-bit word with a valid/ready handshake, and shares the
// RAM port with a preload writer that is served only while the sequencer is idle.
module ifetch_seq #(
  parameter int unsigned     ADDR_W   = 8,
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_out,
  output logic [PC_W-1:0]   inst_pc,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              ld_ready,
  output logic              busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [PC_W-1:0] pc_q, pc_d;
  // Bytes 0..2 of the word; byte 3 arrives in DRAIN and goes straight into inst_out.
  logic [7:0]      b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
  logic            inst_valid_d;
  logic [31:0]     inst_out_d;
  logic [PC_W-1:0] inst_pc_d;

  // Next-state logic: fetch sequencing, word assembly, handshake and redirect.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_d         = pc_q;
    b0_d         = b0_q;
    b1_d         = b1_q;
    b2_d         = b2_q;
    inst_valid_d = inst_valid;
    inst_out_d   = inst_out;
    inst_pc_d    = inst_pc;

    case (state_q)
      S_IDLE: begin
        // Loader has priority over starting a fetch.
        if (!ld_valid && fetch_en) begin
          state_d = S_FETCH;
          cnt_d   = 2'd0;
        end
      end
      S_FETCH: begin
        // Read data lags the issued address by one cycle.
        unique case (cnt_q)
          2'd1:    b0_d = ram_rdata;
          2'd2:    b1_d = ram_rdata;
          2'd3:    b2_d = ram_rdata;
          default: ;
        endcase
        if (cnt_q == 2'd3) begin
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_DRAIN: begin
        inst_out_d   = {b0_q, b1_q, b2_q, ram_rdata};
        inst_pc_d    = pc_q;
        inst_valid_d = 1'b1;
        state_d      = S_OUT;
      end
      default: begin // S_OUT
        if (inst_ready) begin
          inst_valid_d = 1'b0;
          pc_d         = pc_q + PC_W'(4);
          cnt_d        = 2'd0;
          state_d      = (!ld_valid && fetch_en) ? S_FETCH : S_IDLE;
        end
      end
    endcase

    // Redirect overrides everything: drop partial/presented word, restart aligned.
    if (redirect) begin
      pc_d         = redirect_pc & ~PC_W'(3);
      inst_valid_d = 1'b0;
      cnt_d        = 2'd0;
      state_d      = fetch_en ? S_FETCH : S_IDLE;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 2'd0;
      pc_q       <= RESET_PC;
      b0_q       <= 8'h00;
      b1_q       <= 8'h00;
      b2_q       <= 8'h00;
      inst_valid <= 1'b0;
      inst_out   <= 32'h0;
      inst_pc    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      b0_q       <= b0_d;
      b1_q       <= b1_d;
      b2_q       <= b2_d;
      inst_valid <= inst_valid_d;
      inst_out   <= inst_out_d;
      inst_pc    <= inst_pc_d;
    end
  end

  // RAM port mux: preload writes in IDLE, sequential reads in FETCH, quiet otherwise.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = 8'h00;
    ld_ready  = 1'b0;
    if (!reset) begin
      if (state_q == S_IDLE && ld_valid) begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = ld_addr;
        ram_wdata = ld_data;
        ld_ready  = 1'b1;
      end else if (state_q == S_FETCH) begin
        ram_en   = 1'b1;
        ram_addr = pc_q[ADDR_W-1:0] + ADDR_W'(cnt_q);
      end
    end
  end

  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_ifetch_seq.sv
// Bench for ifetch_seq: a byte RAM device on the DUT port, a transaction-level
// model (expected memory image + program counter), directed scenarios, then
// randomized traffic checked by the same per-cycle scoreboard.
module tb_ifetch_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en, redirect, inst_ready, ld_valid;
  logic [31:0] redirect_pc;
  logic [7:0]  ld_addr, ld_data;
  logic        inst_valid, ram_en, ram_we, ld_ready, busy;
  logic [31:0] inst_out, inst_pc;
  logic [7:0]  ram_addr, ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  ifetch_seq dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .redirect(redirect),
    .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_out(inst_out), .inst_pc(inst_pc), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .busy(busy)
  );

  function automatic logic [7:0] init_byte(int i);
    return 8'(i * 37 + 11) ^ 8'h5a;
  endfunction

  // RAM device with 1-cycle read latency.
  logic [7:0] ram [256];
  bit         ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_byte(i);
      ram_init <= 1'b1;
    end else if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram[ram_addr];
    end
  end

  // Reference model state.
  logic [7:0]  exp_mem [256];
  logic [31:0] m_pc;
  bit          hold;
  logic [31:0] h_out, h_pc;
  int          n_hs;
  int          n_total = 0;
  int          n_bad   = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_at(logic [7:0] a);
    logic [7:0] a1, a2, a3;
    a1 = a + 8'd1;
    a2 = a + 8'd2;
    a3 = a + 8'd3;
    return {exp_mem[a], exp_mem[a1], exp_mem[a2], exp_mem[a3]};
  endfunction

  // One clock: check/update the model at negedge, then advance past posedge.
  task automatic tick();
    @(negedge clk);
    if (reset) begin
      m_pc = 32'h0;
      hold = 1'b0;
    end else begin
      chk("ld_ready_rule", ld_ready, ld_valid && !busy);
      if (ld_valid && !busy) begin
        chk("ld_ram_en", ram_en, 1);
        chk("ld_ram_we", ram_we, 1);
        chk("ld_ram_addr", ram_addr, ld_addr);
        chk("ld_ram_wdata", ram_wdata, ld_data);
        exp_mem[ld_addr] = ld_data;
      end
      if (inst_valid) chk("out_ram_quiet", ram_en, 0);
      if (hold) begin
        chk("hold_valid", inst_valid, 1);
        chk("hold_out", inst_out, h_out);
        chk("hold_pc", inst_pc, h_pc);
      end
      if (inst_valid && inst_ready) begin
        chk("word_pc", inst_pc, m_pc);
        chk("word_data", inst_out, word_at(m_pc[7:0]));
        n_hs++;
      end
      hold  = inst_valid && !inst_ready && !redirect;
      h_out = inst_out;
      h_pc  = inst_pc;
      if (redirect) m_pc = redirect_pc & ~32'd3;
      else if (inst_valid && inst_ready) m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(int bound, output int n);
    n = 0;
    while (!inst_valid && n < bound) begin
      tick();
      n++;
    end
    if (!inst_valid) chk("valid_timeout", 0, 1);
  endtask

  task automatic preload(logic [7:0] a, logic [7:0] d);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    #1 chk("pre_ld_ready", ld_ready, 1);
    tick();
    ld_valid = 1'b0;
  endtask

  int n;
  int hs_before;

  initial begin
    for (int i = 0; i < 256; i++) exp_mem[i] = init_byte(i);
    m_pc = 0; hold = 0; n_hs = 0;
    reset = 1'b1; fetch_en = 0; redirect = 0; inst_ready = 0; redirect_pc = 0;
    ld_valid = 1'b1; ld_addr = 8'h33; ld_data = 8'hAA;

    // Reset held two cycles, loader requesting: nothing may reach the RAM.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", inst_valid, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out", inst_out, 0);
    chk("rst_pc", inst_pc, 0);
    ld_valid = 1'b0;
    reset = 1'b0;
    repeat (3) tick();
    chk("idle_valid", inst_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_ram_en", ram_en, 0);

    // Preload then fetch: 6-cycle latency from the decision cycle.
    preload(8'h00, 8'hE3);
    preload(8'h01, 8'hA0);
    preload(8'h02, 8'h10);
    preload(8'h03, 8'h05);
    fetch_en = 1'b1;
    wait_valid(40, n);
    chk("first_latency", n, 6);
    chk("first_word", inst_out, 32'hE3A01005);
    chk("first_pc", inst_pc, 0);

    // Backpressure for 10 cycles: word held, RAM idle.
    repeat (10) tick();
    chk("bp_valid", inst_valid, 1);
    chk("bp_pc", inst_pc, 0);
    inst_ready = 1'b1;
    hs_before = n_hs;
    tick();
    chk("bp_one_hs", n_hs - hs_before, 1);
    chk("bp_drop", inst_valid, 0);
    // Handshake cycle already counted as the first of six.
    wait_valid(40, n);
    chk("b2b_latency", n, 5);
    chk("second_pc", inst_pc, 4);
    tick();
    wait_valid(40, n);
    chk("b2b_latency2", n, 5);
    chk("third_pc", inst_pc, 8);

    // Redirect at FETCH c=2: partial word discarded.
    tick();                 // handshake -> FETCH c0
    tick();                 // c1
    tick();                 // c2
    redirect = 1'b1;
    redirect_pc = 32'h0000_002E;
    tick();
    redirect = 1'b0;
    wait_valid(40, n);
    chk("redir_latency", n, 5);
    chk("redir_pc", inst_pc, 32'h2C);
    chk("redir_word", inst_out, word_at(8'h2C));

    // Wrap: redirect to 0xFC with fetch disabled, preload, then fetch.
    inst_ready = 1'b0;
    fetch_en = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h0000_00FC;
    tick();
    redirect = 1'b0;
    chk("wrap_idle", busy, 0);
    chk("wrap_dropped", inst_valid, 0);
    preload(8'hFC, 8'h11);
    preload(8'hFD, 8'h22);
    preload(8'hFE, 8'h33);
    preload(8'hFF, 8'h44);
    preload(8'h00, 8'h55);
    preload(8'h01, 8'h66);
    preload(8'h02, 8'h77);
    preload(8'h03, 8'h88);
    fetch_en = 1'b1;
    wait_valid(40, n);
    chk("wrap_word", inst_out, 32'h11223344);
    chk("wrap_pc", inst_pc, 32'hFC);
    inst_ready = 1'b1;
    tick();
    wait_valid(40, n);
    chk("wrap_next_pc", inst_pc, 32'h100);
    chk("wrap_next_word", inst_out, 32'h55667788);

    // Loader vs a word sitting in OUT.
    inst_ready = 1'b0;
    ld_valid = 1'b1;
    ld_addr = 8'h80;
    ld_data = 8'h99;
    #1 chk("ldw_blocked", ld_ready, 0);
    repeat (4) tick();
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    #1;
    chk("ldw_idle", busy, 0);
    chk("ldw_ready", ld_ready, 1);
    for (int i = 1; i < 4; i++) begin
      ld_addr = 8'(8'h80 + i);
      ld_data = 8'(8'h90 + i);
      tick();
    end
    ld_valid = 1'b0;
    wait_valid(40, n);
    chk("ldw_resume_lat", n, 6);
    chk("ldw_resume_pc", inst_pc, 32'h104);

    // Asynchronous reset in the middle of a fetch.
    inst_ready = 1'b1;
    tick();
    tick();
    chk("pre_rst_en", ram_en, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_ram_en", ram_en, 0);
    chk("arst_valid", inst_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_out", inst_out, 0);
    tick();
    reset = 1'b0;
    wait_valid(40, n);
    chk("post_rst_pc", inst_pc, 0);

    // Randomized traffic against the scoreboard.
    hs_before = n_hs;
    for (int i = 0; i < 4000; i++) begin
      fetch_en    = ($urandom % 8) != 0;
      inst_ready  = ($urandom % 3) != 0;
      ld_valid    = ($urandom % 6) == 0;
      ld_addr     = 8'($urandom);
      ld_data     = 8'($urandom);
      redirect    = ($urandom % 40) == 0;
      redirect_pc = $urandom;
      tick();
    end
    chk("rand_progress", (n_hs - hs_before) >= 100, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
